// File: rtl/dbus_fabric.sv
// Data-bus interconnect: decodes CPU data-port requests onto NUM_SLV peripherals with wait states, timeout and bus errors.
// Optional error capture log enabled with `define DBUS_FABRIC_ERRLOG_EN.
module dbus_fabric #(
    parameter int                        NUM_SLV     = 4,
    parameter int                        ADDR_W      = 64,
    parameter int                        DATA_W      = 64,
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = {64'hFFFF0000, 64'hFF000000,
                                                        64'h10010000, 64'h0},
    parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = {64'hFFFFFFFFFFFFFF00, 64'hFFFFFFFFFF000000,
                                                        64'hFFFFFFFFFFFF0000, 64'hFFFFFFFFFFF00000},
    parameter int                        TIMEOUT_CYC = 16,
    parameter logic [DATA_W-1:0]         ERR_DATA    = 64'hDEADBEEFDEADBEEF
) (
    input  logic                      iCLK,
    input  logic                      iRST,
    input  logic                      iMReadEnable,
    input  logic                      iMWriteEnable,
    input  logic [DATA_W/8-1:0]       iMByteEnable,
    input  logic [ADDR_W-1:0]         iMAddress,
    input  logic [DATA_W-1:0]         iMWriteData,
    output logic [DATA_W-1:0]         oMReadData,
    output logic                      oMStall,
    output logic                      oMBusErr,
    output logic [NUM_SLV-1:0]        oSReadEnable,
    output logic [NUM_SLV-1:0]        oSWriteEnable,
    output logic [DATA_W/8-1:0]       oSByteEnable,
    output logic [ADDR_W-1:0]         oSAddress,
    output logic [DATA_W-1:0]         oSWriteData,
    input  logic [NUM_SLV*DATA_W-1:0] iSReadData,
    input  logic [NUM_SLV-1:0]        iSReady,
`ifdef DBUS_FABRIC_ERRLOG_EN
    input  logic                      iErrClr,
    output logic                      oErrValid,
    output logic [ADDR_W-1:0]         oErrAddr,
    output logic                      oErrIsWrite,
`endif
    output logic [15:0]               oErrCount
);

    localparam int SEL_W   = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int CNT_W   = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int TO_LAST = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST_V = CNT_W'(TO_LAST);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_DONE,
        ST_ERR
    } state_t;

    state_t             state;
    state_t             next_state;
    logic               req;
    logic               conflict;
    logic               hit;
    logic [SEL_W-1:0]   hit_idx;
    logic [NUM_SLV-1:0] hit_onehot;
    logic [SEL_W-1:0]   sel_idx;
    logic               sel_ready;
    logic [DATA_W-1:0]  sel_rdata;
    logic               is_write;
    logic [CNT_W-1:0]   to_cnt;
    logic               timeout_hit;

    assign req      = iMReadEnable | iMWriteEnable;
    assign conflict = iMReadEnable & iMWriteEnable;

    // Iterating downwards lets the lowest matching index overwrite any higher match.
    always_comb begin
        hit        = 1'b0;
        hit_idx    = '0;
        hit_onehot = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if ((iMAddress & SLV_MASK[i*ADDR_W +: ADDR_W]) == SLV_BASE[i*ADDR_W +: ADDR_W]) begin
                hit     = 1'b1;
                hit_idx = SEL_W'(i);
            end
        end
        for (int i = 0; i < NUM_SLV; i++) begin
            if (hit && (hit_idx == SEL_W'(i))) begin
                hit_onehot[i] = 1'b1;
            end
        end
    end

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        for (int i = 0; i < NUM_SLV; i++) begin
            if (sel_idx == SEL_W'(i)) begin
                sel_ready = iSReady[i];
                sel_rdata = iSReadData[i*DATA_W +: DATA_W];
            end
        end
    end

    assign timeout_hit = (TIMEOUT_CYC != 0) && (to_cnt == TO_LAST_V);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (req) begin
                    next_state = (!hit || conflict) ? ST_ERR : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (sel_ready) begin
                    next_state = ST_DONE;
                end else if (timeout_hit) begin
                    next_state = ST_ERR;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            ST_ERR:   next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        oMStall = 1'b0;
        if ((state == ST_IDLE) || (state == ST_ACCESS)) begin
            oMStall = req;
        end
    end

    // Request latch and slave strobes; the latched copy is what the slave sees for the whole access.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oSAddress     <= '0;
            oSWriteData   <= '0;
            oSByteEnable  <= '0;
            oSReadEnable  <= '0;
            oSWriteEnable <= '0;
            sel_idx       <= '0;
            is_write      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req) begin
                        oSAddress    <= iMAddress;
                        oSWriteData  <= iMWriteData;
                        oSByteEnable <= iMByteEnable;
                        sel_idx      <= hit_idx;
                        is_write     <= iMWriteEnable;
                        if (hit && !conflict) begin
                            oSReadEnable  <= iMReadEnable  ? hit_onehot : '0;
                            oSWriteEnable <= iMWriteEnable ? hit_onehot : '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (next_state != ST_ACCESS) begin
                        oSReadEnable  <= '0;
                        oSWriteEnable <= '0;
                    end
                end
                default: begin
                    oSReadEnable  <= '0;
                    oSWriteEnable <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            to_cnt <= '0;
        end else if ((state == ST_ACCESS) && (next_state == ST_ACCESS)) begin
            to_cnt <= to_cnt + 1'b1;
        end else begin
            to_cnt <= '0;
        end
    end

    // Master-side response registers are loaded on the edge entering DONE or ERR.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oMReadData <= '0;
            oMBusErr   <= 1'b0;
            oErrCount  <= '0;
        end else begin
            oMBusErr <= (next_state == ST_ERR);
            if (next_state == ST_ERR) begin
                oMReadData <= ERR_DATA;
                if (oErrCount != 16'hFFFF) begin
                    oErrCount <= oErrCount + 16'd1;
                end
            end else if ((state == ST_ACCESS) && sel_ready && !is_write) begin
                oMReadData <= sel_rdata;
            end
        end
    end

`ifdef DBUS_FABRIC_ERRLOG_EN
    logic err_entry;

    assign err_entry = (next_state == ST_ERR);

    // A clear arriving together with a new error re-arms the log with that error.
    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            oErrValid   <= 1'b0;
            oErrAddr    <= '0;
            oErrIsWrite <= 1'b0;
        end else if (err_entry && (!oErrValid || iErrClr)) begin
            oErrValid   <= 1'b1;
            oErrAddr    <= (state == ST_IDLE) ? iMAddress     : oSAddress;
            oErrIsWrite <= (state == ST_IDLE) ? iMWriteEnable : is_write;
        end else if (iErrClr) begin
            oErrValid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_dbus_fabric.sv
// Randomized transaction-level bench for dbus_fabric against a decode/latency reference model.
module tb_dbus_fabric;

    localparam int NUM_SLV = 4;
    localparam int TIMEOUT = 16;
    localparam logic [63:0] ERR_DATA = 64'hDEADBEEFDEADBEEF;

    logic         iCLK = 1'b0;
    logic         iRST = 1'b0;
    logic         iMReadEnable = 1'b0;
    logic         iMWriteEnable = 1'b0;
    logic [7:0]   iMByteEnable = '0;
    logic [63:0]  iMAddress = '0;
    logic [63:0]  iMWriteData = '0;
    logic [63:0]  oMReadData;
    logic         oMStall;
    logic         oMBusErr;
    logic [3:0]   oSReadEnable;
    logic [3:0]   oSWriteEnable;
    logic [7:0]   oSByteEnable;
    logic [63:0]  oSAddress;
    logic [63:0]  oSWriteData;
    logic [255:0] iSReadData = '0;
    logic [3:0]   iSReady = '0;
    logic [15:0]  oErrCount;
`ifdef DBUS_FABRIC_ERRLOG_EN
    logic         iErrClr = 1'b0;
    logic         oErrValid;
    logic [63:0]  oErrAddr;
    logic         oErrIsWrite;
`endif

    dbus_fabric dut (
        .iCLK          (iCLK),
        .iRST          (iRST),
        .iMReadEnable  (iMReadEnable),
        .iMWriteEnable (iMWriteEnable),
        .iMByteEnable  (iMByteEnable),
        .iMAddress     (iMAddress),
        .iMWriteData   (iMWriteData),
        .oMReadData    (oMReadData),
        .oMStall       (oMStall),
        .oMBusErr      (oMBusErr),
        .oSReadEnable  (oSReadEnable),
        .oSWriteEnable (oSWriteEnable),
        .oSByteEnable  (oSByteEnable),
        .oSAddress     (oSAddress),
        .oSWriteData   (oSWriteData),
        .iSReadData    (iSReadData),
        .iSReady       (iSReady),
`ifdef DBUS_FABRIC_ERRLOG_EN
        .iErrClr       (iErrClr),
        .oErrValid     (oErrValid),
        .oErrAddr      (oErrAddr),
        .oErrIsWrite   (oErrIsWrite),
`endif
        .oErrCount     (oErrCount)
    );

    always #5 iCLK = ~iCLK;

    int checks = 0;
    int failures = 0;
    logic [63:0] model_rdata = '0;
    int          model_errs = 0;

    logic [63:0] base_tbl [4] = '{64'h0, 64'h10010000, 64'hFF000000, 64'hFFFF0000};
    logic [63:0] mask_tbl [4] = '{64'hFFFFFFFFFFF00000, 64'hFFFFFFFFFFFF0000,
                                  64'hFFFFFFFFFF000000, 64'hFFFFFFFFFFFFFF00};

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int expectedSlave(input logic [63:0] addr);
        for (int i = 0; i < NUM_SLV; i++) begin
            if ((addr & mask_tbl[i]) == base_tbl[i]) return i;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        @(negedge iCLK);
    endtask

    // One full master transaction starting in IDLE; wait_cyc is the number of ACCESS cycles before ready.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [63:0] addr,
                                 input logic [63:0] wdata, input logic [7:0] be, input int wait_cyc);
        int          s;
        bit          err;
        int          exp_stall;
        int          stalls;
        bit          ended;
        logic [3:0]  onehot;
        logic [63:0] ready_data;
        s = expectedSlave(addr);
        err = (s < 0) || (rd && wr);
        onehot = (s >= 0) ? (4'b0001 << s) : 4'b0000;
        ready_data = '0;
        if (err) exp_stall = 1;
        else if (wait_cyc < TIMEOUT) exp_stall = wait_cyc + 2;
        else begin
            exp_stall = TIMEOUT + 1;
            err = 1'b1;
        end
        iMReadEnable  = rd;
        iMWriteEnable = wr;
        iMAddress     = addr;
        iMWriteData   = wdata;
        iMByteEnable  = be;
        stalls = 0;
        ended  = 1'b0;
        for (int c = 0; c < TIMEOUT + 8 && !ended; c++) begin
            for (int k = 0; k < NUM_SLV; k++) iSReadData[k*64 +: 64] = {$urandom, $urandom};
            iSReady = 4'($urandom);
            if (s >= 0) begin
                iSReady[s] = (c == wait_cyc + 1);
                if (c == wait_cyc + 1) ready_data = iSReadData[s*64 +: 64];
            end
            #1;
            if (oMStall) begin
                stalls++;
                if (c >= 1) begin
                    checkOutput("acc_rd_strobe", oSReadEnable, rd ? onehot : 4'b0);
                    checkOutput("acc_wr_strobe", oSWriteEnable, wr ? onehot : 4'b0);
                    checkOutput("acc_addr", oSAddress, addr);
                    checkOutput("acc_wdata", oSWriteData, wdata);
                    checkOutput("acc_be", oSByteEnable, be);
                end
            end else begin
                ended = 1'b1;
                checkOutput("stall_cycles", stalls, exp_stall);
                checkOutput("end_rd_strobe", oSReadEnable, 4'b0);
                checkOutput("end_wr_strobe", oSWriteEnable, 4'b0);
                checkOutput("bus_err", oMBusErr, err);
                if (err) begin
                    model_rdata = ERR_DATA;
                    if (model_errs < 65535) model_errs++;
                end else if (rd) begin
                    model_rdata = ready_data;
                end
                checkOutput("read_data", oMReadData, model_rdata);
                checkOutput("err_count", oErrCount, model_errs);
            end
            @(posedge iCLK);
            @(negedge iCLK);
        end
        checkOutput("txn_end", ended, 1'b1);
    endtask

    task automatic idleCycle();
        iMReadEnable  = 1'b0;
        iMWriteEnable = 1'b0;
        iSReady       = 4'($urandom);
        #1;
        checkOutput("idle_stall", oMStall, 1'b0);
        tick();
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [63:0] addr;
        logic [63:0] d;
        int          cls;
        int          op;
        int          w;

        #1;
        checkOutput("rst_rd_strobe", oSReadEnable, 4'b0);
        checkOutput("rst_wr_strobe", oSWriteEnable, 4'b0);
        checkOutput("rst_addr", oSAddress, 64'h0);
        checkOutput("rst_rdata", oMReadData, 64'h0);
        checkOutput("rst_buserr", oMBusErr, 1'b0);
        checkOutput("rst_errcnt", oErrCount, 16'h0);
        @(negedge iCLK);
        iRST = 1'b1;
        tick();

        $display("[TB] directed transactions");
        applyStimulus(1'b1, 1'b0, 64'h40, 64'h0, 8'hFF, 0);
        applyStimulus(1'b0, 1'b1, 64'h10010008, 64'hA5A5_5A5A_0123_4567, 8'h0F, 3);
        idleCycle();
        applyStimulus(1'b1, 1'b0, 64'h20000000, 64'h0, 8'hFF, 0);
        applyStimulus(1'b1, 1'b0, 64'hFF000010, 64'h0, 8'hFF, 20);
        applyStimulus(1'b1, 1'b0, 64'hFF000010, 64'h0, 8'hFF, 15);
        applyStimulus(1'b1, 1'b1, 64'h40, 64'h0, 8'hFF, 0);
        applyStimulus(1'b1, 1'b0, 64'hFFFF0004, 64'h0, 8'hFF, 1);

        // Request withdrawn during ACCESS still completes.
        iMReadEnable = 1'b1;
        iMAddress    = 64'h80;
        iSReady      = 4'b0;
        tick();
        iMReadEnable = 1'b0;
        iMAddress    = 64'h12345678;
        #1;
        checkOutput("wd_stall", oMStall, 1'b0);
        checkOutput("wd_strobe", oSReadEnable, 4'b0001);
        tick();
        d = 64'hCAFE_F00D_1234_ABCD;
        iSReadData[63:0] = d;
        iSReady = 4'b0001;
        tick();
        iSReady = 4'b0;
        #1;
        checkOutput("wd_rdata", oMReadData, d);
        checkOutput("wd_strobe_off", oSReadEnable, 4'b0);
        model_rdata = d;
        tick();

        // Asynchronous reset in the middle of an access.
        iMReadEnable = 1'b1;
        iMAddress    = 64'h10010020;
        iSReady      = 4'b0;
        tick();
        tick();
        checkOutput("pre_rst_strobe", oSReadEnable, 4'b0010);
        #2;
        iRST = 1'b0;
        #1;
        checkOutput("arst_strobe", oSReadEnable, 4'b0);
        checkOutput("arst_rdata", oMReadData, 64'h0);
        checkOutput("arst_errcnt", oErrCount, 16'h0);
        checkOutput("arst_addr", oSAddress, 64'h0);
        model_rdata = '0;
        model_errs  = 0;
        iMReadEnable = 1'b0;
        @(negedge iCLK);
        iRST = 1'b1;
        tick();
        applyStimulus(1'b1, 1'b0, 64'h10010020, 64'h0, 8'hFF, 2);

`ifdef DBUS_FABRIC_ERRLOG_EN
        $display("[TB] error log");
        applyStimulus(1'b1, 1'b0, 64'h20000000, 64'h0, 8'hFF, 0);
        applyStimulus(1'b0, 1'b1, 64'h30000000, 64'h0, 8'hFF, 0);
        checkOutput("log_valid", oErrValid, 1'b1);
        checkOutput("log_addr", oErrAddr, 64'h20000000);
        checkOutput("log_iswrite", oErrIsWrite, 1'b0);
        iErrClr = 1'b1;
        tick();
        iErrClr = 1'b0;
        #1;
        checkOutput("log_cleared", oErrValid, 1'b0);
        tick();
        applyStimulus(1'b0, 1'b1, 64'h30000000, 64'h0, 8'hFF, 0);
        checkOutput("log_valid2", oErrValid, 1'b1);
        checkOutput("log_addr2", oErrAddr, 64'h30000000);
        checkOutput("log_iswrite2", oErrIsWrite, 1'b1);
`endif

        $display("[TB] random transactions");
        for (int n = 0; n < 200; n++) begin
            cls = $urandom_range(0, 6);
            case (cls)
                0: addr = {44'h0, 20'($urandom)};
                1: addr = {48'h1001, 16'($urandom)};
                2: addr = {40'hFF, 24'($urandom)};
                3: addr = {56'hFFFF00, 8'($urandom)};
                4: addr = 64'h20000000 + 64'($urandom_range(0, 255));
                5: addr = {$urandom, $urandom};
                default: addr = {48'h1002, 16'($urandom)};
            endcase
            op = $urandom_range(0, 9);
            w  = ($urandom_range(0, 4) == 0) ? $urandom_range(12, 20) : $urandom_range(0, 3);
            applyStimulus(op >= 1 && op <= 5 || op == 0, op == 0 || op > 5, addr,
                          {$urandom, $urandom}, 8'($urandom), w);
            if ($urandom_range(0, 1) == 1) idleCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dbus_fabric.md
Name: dbus_fabric

Overview:
- Parametrised data-bus interconnect between the CPU data port and NUM_SLV peripherals: data memory, VGA, break unit and future devices.
- Successor to the fixed, point-to-point shared data bus: replaces broadcast wiring with address decode, one-hot slave strobes, a ready/wait-state handshake, a timeout, and bus-error signalling.
- Sits between CPU and peripherals in the top level; all outputs registered except oMStall.

Parameters:
NUM_SLV, 4, number of slave channels (1..8)
ADDR_W, 64, address width
DATA_W, 64, data width (multiple of 8)
SLV_BASE, {64'h0,64'h10010000,64'hFF000000,64'hFFFF0000}, packed NUM_SLV*ADDR_W base addresses, slave 0 in LSBs
SLV_MASK, {64'hFFFFFFFFFFF00000,64'hFFFFFFFFFFFF0000,64'hFFFFFFFFFF000000,64'hFFFFFFFFFFFFFF00}, packed decode masks
TIMEOUT_CYC, 16, max ACCESS cycles before error; 0 disables timeout
ERR_DATA, 64'hDEADBEEFDEADBEEF, read data returned on error

Ports:
iCLK  in  1  fabric clock (CPU clock)
iRST  in  1  asynchronous reset, active-low
iMReadEnable  in  1  master read request
iMWriteEnable  in  1  master write request
iMByteEnable  in  DATA_W/8  byte lanes
iMAddress  in  ADDR_W  request address
iMWriteData  in  DATA_W  write data
oMReadData  out  DATA_W  read data, valid in DONE/ERR
oMStall  out  1  hold request; master must not advance
oMBusErr  out  1  one-cycle error pulse
oSReadEnable  out  NUM_SLV  one-hot slave read strobe
oSWriteEnable  out  NUM_SLV  one-hot slave write strobe
oSByteEnable  out  DATA_W/8  shared latched byte lanes
oSAddress  out  ADDR_W  shared latched address
oSWriteData  out  DATA_W  shared latched write data
iSReadData  in  NUM_SLV*DATA_W  per-slave read data
iSReady  in  NUM_SLV  per-slave completion
oErrCount  out  16  saturating error counter

Behaviour:
- Reset (iRST=0, async): state IDLE; all slave strobes 0; oSAddress/oSWriteData/oSByteEnable 0; oMReadData 0; oMBusErr 0; oErrCount 0; timeout counter 0.
- FSM states: IDLE, ACCESS, DONE, ERR.
- oMStall = (iMReadEnable|iMWriteEnable) & (state==IDLE | state==ACCESS). Combinational.
- IDLE, request present: latch address, data and byte lanes. Decode picks the lowest index i with (iMAddress & MASK_i)==BASE_i.
  - Hit: assert oSReadEnable[i] or oSWriteEnable[i], go to ACCESS.
  - No hit, or read and write both asserted: go to ERR.
- ACCESS: strobe held. Master inputs are ignored (latched copy used). Timeout counter increments each cycle.
  - iSReady[i]=1: capture iSReadData slice i into oMReadData (reads only; writes leave it unchanged), drop strobes, go to DONE.
  - Else if TIMEOUT_CYC!=0 and counter==TIMEOUT_CYC-1: drop strobes, go to ERR.
  - Ready and timeout in the same cycle: ready wins.
- DONE: one cycle, oMStall=0; master completes at this edge; go to IDLE. The counter clears.
- ERR: one cycle. oMBusErr=1, oMStall=0, oMReadData=ERR_DATA. oErrCount increments, saturating at 16'hFFFF. Go to IDLE.
- Minimum latency, request to completion: 2 stalled cycles (IDLE, ACCESS with immediate ready), then DONE.
- Back-to-back: a request present in the cycle after DONE starts a new transaction. No pipelining; at most one outstanding transaction.
- iSReady of non-selected slaves is ignored.
- Request withdrawn mid-ACCESS: the transaction still completes to DONE; no effect on the slave.
- Async reset mid-ACCESS: strobes drop immediately; no completion or error reported.

Optional Feature:
DBUS_FABRIC_ERRLOG_EN
- With it: adds input iErrClr (1) and outputs oErrValid (1), oErrAddr (ADDR_W), oErrIsWrite (1).
  - First ERR entry captures the latched address and direction and sets oErrValid, which is sticky. Later errors do not overwrite.
  - iErrClr=1 clears oErrValid. iErrClr coinciding with an ERR entry: capture wins, valid stays 1.
  - All three outputs reset to 0.
- Without it: ports absent, no logging; oErrCount still present.

Test Plan:
- Read 0x00000040, slave0 ready in first ACCESS cycle with data 64'h1122334455667788 -> oSReadEnable=4'b0001 for 1 cycle; oMStall high 2 cycles; oMReadData=64'h1122334455667788 in DONE; oMBusErr=0.
- Write 0x10010008 with byte enables 8'h0F, slave1 ready after 3 wait cycles -> oSWriteEnable=4'b0010 for 4 cycles; oSWriteData/oSByteEnable stable throughout; oMStall high 5 cycles.
- Read unmapped 0x20000000 -> no strobe; ERR the next cycle; oMReadData=64'hDEADBEEFDEADBEEF; oMBusErr pulse; oErrCount=1.
- Slave2 never ready, TIMEOUT_CYC=16 -> strobe high exactly 16 cycles, then ERR; oErrCount increments. Repeat with ready arriving in cycle 16 -> DONE, no error.
- Assert iRST=0 during ACCESS -> strobes and outputs 0 asynchronously; after release, a new read completes normally.
- Errlog build: two errors at 0x20000000 (read) then 0x30000000 (write) -> oErrAddr=0x20000000, oErrIsWrite=0; after iErrClr, next error at 0x30000000 captures with oErrIsWrite=1.
